display_cmd_sequencer: RTL

- Upstream driver for the SPI display controller. Runs a fixed power-up command sequence, clears the panel to a fill colour, then turns single-pixel write requests into address-window, RAMWR and colour transfers.
- Issues one transfer at a time on the controller's DATA/LEN/MODE/WE/READY interface.
- Sits between pixel-producing logic (renderer/UART bridge) and the SPI controller.

---
 rtl/display_cmd_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/display_cmd_sequencer.sv
// Display command sequencer: drives the SPI display controller through the
// panel power-up commands, clears the panel to FILL_COLOR, then converts
// single-pixel requests into window + RAMWR + colour transfers. Exactly one
// transfer is in flight at a time, using an ISSUE/HOLD/WAIT handshake.
module display_cmd_sequencer #(
    parameter int          WIDTH      = 240,
    parameter int          HEIGHT     = 320,
    parameter logic [15:0] FILL_COLOR = 16'h0000,
    parameter int          MS_CYCLES  = 25000
) (
    input  logic        CLK_25MHz,
    input  logic        RESET,
    input  logic        SPI_READY,
    output logic [15:0] SPI_DATA,
    output logic [3:0]  SPI_LEN,
    output logic        SPI_MODE,
    output logic        SPI_WE,
    input  logic        PIX_VALID,
    input  logic [8:0]  PIX_X,
    input  logic [8:0]  PIX_Y,
    input  logic [15:0] PIX_COLOR,
    output logic        PIX_READY,
    output logic        INIT_DONE
);

    typedef enum logic [2:0] {
        ST_INIT_ROM,
        ST_INIT_DELAY,
        ST_CLEAR,
        ST_IDLE,
        ST_PIXEL
    } state_t;

    typedef enum logic [1:0] {
        SUB_ISSUE,
        SUB_HOLD,
        SUB_WAIT
    } sub_t;

    // One controller transfer: payload, command/data select, byte/halfword size
    typedef struct packed {
        logic [15:0] data;
        logic        mode;
        logic        half;
    } xfer_t;

    localparam logic [16:0] PIX_LAST   = 17'(WIDTH * HEIGHT - 1);
    localparam logic [31:0] DELAY_150  = 32'(150 * MS_CYCLES - 1);
    localparam logic [31:0] DELAY_120  = 32'(120 * MS_CYCLES - 1);
    localparam logic [9:0]  X_LIM      = 10'(WIDTH);
    localparam logic [9:0]  Y_LIM      = 10'(HEIGHT);
    localparam logic [15:0] X_LAST     = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST     = 16'(HEIGHT - 1);
    localparam logic [2:0]  ROM_LAST   = 3'd6;
    localparam logic [2:0]  STEP_COLOR = 3'd7;

    // Power-up command list: software reset, sleep out, 16-bit pixel format,
    // memory access control, display on
    function automatic xfer_t rom_xfer(input logic [2:0] idx);
        xfer_t x;
        x.half = 1'b0;
        x.mode = 1'b0;
        case (idx)
            3'd0:    x.data = 16'h0001;
            3'd1:    x.data = 16'h0011;
            3'd2:    x.data = 16'h003A;
            3'd3:    begin x.data = 16'h0055; x.mode = 1'b1; end
            3'd4:    x.data = 16'h0036;
            3'd5:    begin x.data = 16'h0000; x.mode = 1'b1; end
            default: x.data = 16'h0029;
        endcase
        return x;
    endfunction

    // Address window followed by RAMWR; step 7 is the colour halfword
    function automatic xfer_t win_xfer(input logic [2:0]  step,
                                       input logic [15:0] x0,
                                       input logic [15:0] x1,
                                       input logic [15:0] y0,
                                       input logic [15:0] y1,
                                       input logic [15:0] color);
        xfer_t x;
        x.mode = 1'b1;
        x.half = 1'b1;
        x.data = color;
        case (step)
            3'd0:    begin x.data = 16'h002A; x.mode = 1'b0; x.half = 1'b0; end
            3'd1:    x.data = x0;
            3'd2:    x.data = x1;
            3'd3:    begin x.data = 16'h002B; x.mode = 1'b0; x.half = 1'b0; end
            3'd4:    x.data = y0;
            3'd5:    x.data = y1;
            3'd6:    begin x.data = 16'h002C; x.mode = 1'b0; x.half = 1'b0; end
            default: x.data = color;
        endcase
        return x;
    endfunction

    state_t      state;
    sub_t        sub;
    logic        hold_cnt;
    logic [2:0]  rom_idx;
    logic [2:0]  step;
    logic [16:0] pix_cnt;
    logic [31:0] delay_cnt;
    logic [31:0] delay_end;
    logic [8:0]  px_x;
    logic [8:0]  px_y;
    logic [15:0] px_color;
    logic        px_bad;
    xfer_t       cur_xfer;
    logic        xfer_done;
    logic        xfer_active;

    // Select the transfer the current state wants to send next
    always_comb begin
        cur_xfer = rom_xfer(rom_idx);
        if (state == ST_CLEAR)
            cur_xfer = win_xfer(step, 16'h0000, X_LAST, 16'h0000, Y_LAST, FILL_COLOR);
        else if (state == ST_PIXEL)
            cur_xfer = win_xfer(step, {7'b0, px_x}, {7'b0, px_x},
                                {7'b0, px_y}, {7'b0, px_y}, px_color);
    end

    assign xfer_done   = (sub == SUB_WAIT) && SPI_READY;
    assign xfer_active = (state == ST_INIT_ROM) || (state == ST_CLEAR) ||
                         ((state == ST_PIXEL) && !px_bad);

    // Main sequencer: top-level state plus the shared ISSUE/HOLD/WAIT handshake
    always_ff @(posedge CLK_25MHz) begin
        if (RESET) begin
            state     <= ST_INIT_ROM;
            sub       <= SUB_ISSUE;
            hold_cnt  <= 1'b0;
            rom_idx   <= 3'd0;
            step      <= 3'd0;
            pix_cnt   <= 17'd0;
            delay_cnt <= 32'd0;
            delay_end <= 32'd0;
            SPI_WE    <= 1'b0;
            SPI_DATA  <= 16'h0000;
            SPI_LEN   <= 4'd0;
            SPI_MODE  <= 1'b0;
            PIX_READY <= 1'b0;
            INIT_DONE <= 1'b0;
        end else begin
            SPI_WE <= 1'b0;

            // HOLD spans the strobe cycle and the following one, so the
            // controller's late READY drop is never mistaken for idle.
            if (xfer_active) begin
                case (sub)
                    SUB_ISSUE: begin
                        if (SPI_READY) begin
                            SPI_WE   <= 1'b1;
                            SPI_DATA <= cur_xfer.data;
                            SPI_LEN  <= cur_xfer.half ? 4'd15 : 4'd7;
                            SPI_MODE <= cur_xfer.mode;
                            sub      <= SUB_HOLD;
                            hold_cnt <= 1'b0;
                        end
                    end
                    SUB_HOLD: begin
                        if (hold_cnt)
                            sub <= SUB_WAIT;
                        hold_cnt <= 1'b1;
                    end
                    default: begin
                        if (SPI_READY)
                            sub <= SUB_ISSUE;
                    end
                endcase
            end

            case (state)
                ST_INIT_ROM: begin
                    if (xfer_done) begin
                        if (rom_idx == 3'd0) begin
                            state     <= ST_INIT_DELAY;
                            delay_end <= DELAY_150;
                            delay_cnt <= 32'd0;
                        end else if (rom_idx == 3'd1) begin
                            state     <= ST_INIT_DELAY;
                            delay_end <= DELAY_120;
                            delay_cnt <= 32'd0;
                        end else if (rom_idx == ROM_LAST) begin
                            state   <= ST_CLEAR;
                            step    <= 3'd0;
                            pix_cnt <= 17'd0;
                        end else begin
                            rom_idx <= rom_idx + 3'd1;
                        end
                    end
                end
                ST_INIT_DELAY: begin
                    if (delay_cnt == delay_end) begin
                        state   <= ST_INIT_ROM;
                        rom_idx <= rom_idx + 3'd1;
                    end else begin
                        delay_cnt <= delay_cnt + 32'd1;
                    end
                end
                ST_CLEAR: begin
                    if (xfer_done) begin
                        if (step != STEP_COLOR) begin
                            step <= step + 3'd1;
                        end else if (pix_cnt == PIX_LAST) begin
                            state     <= ST_IDLE;
                            INIT_DONE <= 1'b1;
                            PIX_READY <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + 17'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (PIX_VALID && PIX_READY) begin
                        state     <= ST_PIXEL;
                        step      <= 3'd0;
                        PIX_READY <= 1'b0;
                    end
                end
                ST_PIXEL: begin
                    if (px_bad || (xfer_done && step == STEP_COLOR)) begin
                        state     <= ST_IDLE;
                        PIX_READY <= 1'b1;
                    end else if (xfer_done) begin
                        step <= step + 3'd1;
                    end
                end
                default: state <= ST_INIT_ROM;
            endcase
        end
    end

    // Capture the accepted pixel request and flag off-panel coordinates
    always_ff @(posedge CLK_25MHz) begin
        if (state == ST_IDLE && PIX_VALID && PIX_READY) begin
            px_x     <= PIX_X;
            px_y     <= PIX_Y;
            px_color <= PIX_COLOR;
            px_bad   <= ({1'b0, PIX_X} >= X_LIM) || ({1'b0, PIX_Y} >= Y_LIM);
        end
    end

endmodule
